// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing for the ultrasonic ranger controller.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  typedef logic [15:0] tick_t;

  localparam int unsigned CLK_FREQ_HZ_DEF     = 27_000_000;
  localparam int unsigned TRIG_CYCLES_DEF     = 270;
  localparam int unsigned ECHO_TIMEOUT_US_DEF = 38000;
  localparam int unsigned HOLDOFF_US_DEF      = 60000;

  function automatic tick_t sat_inc(input tick_t v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: counts 0..DIV-1 and flags the wrap cycle; clr_i restarts the count.
module us_tick_gen #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Tick is not gated by clr_i so the FSM next-state logic stays loop-free.
  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/ultrasonic_ranger_ctrl.sv
// HC-SR04 style ranger: issues trig, waits for echo, times the echo high width in us ticks.
// IDLE: wait start/auto | TRIG: trig high | WAIT_RISE: await echo | MEASURE: time echo | HOLDOFF: pace repeats
module ultrasonic_ranger_ctrl
  import ultrasonic_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = CLK_FREQ_HZ_DEF,
  parameter int unsigned TICK_DIV        = CLK_FREQ_HZ / 1_000_000,
  parameter int unsigned TRIG_CYCLES     = TRIG_CYCLES_DEF,
  parameter int unsigned ECHO_TIMEOUT_US = ECHO_TIMEOUT_US_DEF,
  parameter int unsigned HOLDOFF_US      = HOLDOFF_US_DEF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start_i,
  input  logic        auto_en_i,
  input  logic        echo_i,
  output logic        trig_o,
  output logic        busy_o,
  output logic [15:0] result_us_o,
  output logic        result_valid_o,
  output logic        timeout_o
);

  localparam tick_t TRIG_LAST = tick_t'(TRIG_CYCLES - 1);
  localparam tick_t TO_LIM    = tick_t'(ECHO_TIMEOUT_US);
  localparam tick_t HO_LIM    = tick_t'(HOLDOFF_US);

  state_t state_q, state_d;
  logic   echo_meta_q, echo_s_q, echo_prev_q;
  logic   echo_rise, echo_fall;
  logic   entry, ho_clr, tick, ho_tick;
  tick_t  tick_cnt_q, tick_inc, ho_cnt_q, ho_inc, trig_cnt_q;
  tick_t  result_q, result_d;
  logic   trig_q, done_q, done_d, rv_q, rv_d, to_q, to_d;
  logic   to_hit, ho_done;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_prev_q <= 1'b0;
    end else begin
      echo_meta_q <= echo_i;
      echo_s_q    <= echo_meta_q;
      echo_prev_q <= echo_s_q;
    end
  end

  assign echo_rise = echo_s_q & ~echo_prev_q;
  assign echo_fall = ~echo_s_q & echo_prev_q;

  assign entry  = (state_d != state_q);
  assign ho_clr = entry && (state_d == TRIG);

  us_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .nrst   (nrst),
    .clr_i  (entry),
    .tick_o (tick)
  );

  // Holdoff has its own prescaler so its phase survives the per-state clears.
  us_tick_gen #(.DIV(TICK_DIV)) u_ho_tick (
    .clk    (clk),
    .nrst   (nrst),
    .clr_i  (ho_clr),
    .tick_o (ho_tick)
  );

  assign tick_inc = tick    ? sat_inc(tick_cnt_q) : tick_cnt_q;
  assign ho_inc   = ho_tick ? sat_inc(ho_cnt_q)   : ho_cnt_q;
  assign to_hit   = (tick_inc >= TO_LIM);
  assign ho_done  = (ho_inc >= HO_LIM);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rv_d     = 1'b0;
    to_d     = 1'b0;
    done_d   = done_q;
    case (state_q)
      IDLE: begin
        if (start_i || (auto_en_i && done_q)) state_d = TRIG;
      end
      TRIG: begin
        if (trig_cnt_q == TRIG_LAST) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (echo_rise) begin
          state_d = MEASURE;
        end else if (to_hit) begin
          to_d    = 1'b1;
          state_d = HOLDOFF;
        end
      end
      MEASURE: begin
        // A fall coinciding with the limit still yields a valid width.
        if (echo_fall) begin
          result_d = tick_inc;
          rv_d     = 1'b1;
          state_d  = HOLDOFF;
        end else if (to_hit) begin
          to_d    = 1'b1;
          state_d = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (ho_done) state_d = auto_en_i ? TRIG : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == HOLDOFF) && (state_d == IDLE)) done_d = 1'b1;
    if (ho_clr) done_d = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      ho_cnt_q   <= '0;
      trig_cnt_q <= '0;
      result_q   <= '0;
      trig_q     <= 1'b0;
      done_q     <= 1'b0;
      rv_q       <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= entry ? '0 : tick_inc;
      ho_cnt_q   <= ho_clr ? '0 : ho_inc;
      trig_cnt_q <= ((state_q == TRIG) && !entry) ? trig_cnt_q + 16'd1 : '0;
      result_q   <= result_d;
      trig_q     <= (state_d == TRIG);
      done_q     <= done_d;
      rv_q       <= rv_d;
      to_q       <= to_d;
    end
  end

  assign trig_o         = trig_q;
  assign busy_o         = (state_q != IDLE);
  assign result_us_o    = result_q;
  assign result_valid_o = rv_q;
  assign timeout_o      = to_q;

endmodule

// File: tb/tb_ultrasonic_ranger_ctrl.sv
// Directed bench for ultrasonic_ranger_ctrl with TICK_DIV=4, TRIG_CYCLES=10, timeout 100, holdoff 200.
module tb_ultrasonic_ranger_ctrl;

  logic        clk = 1'b0;
  logic        nrst, start, auto_en, echo;
  logic        trig, busy, rv, to;
  logic [15:0] result;

  int   n_cmp = 0, n_bad = 0, nc = 0;
  int   n_rv = 0, n_to = 0, n_both = 0, n_rise = 0;
  logic trig_prev_m = 1'b0;
  int   r0, e0, rv0, to0, rise0, hi, t_to;
  int   rise_at [3];

  always #5 clk = ~clk;

  ultrasonic_ranger_ctrl #(
    .TICK_DIV        (4),
    .TRIG_CYCLES     (10),
    .ECHO_TIMEOUT_US (100),
    .HOLDOFF_US      (200)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .start_i        (start),
    .auto_en_i      (auto_en),
    .echo_i         (echo),
    .trig_o         (trig),
    .busy_o         (busy),
    .result_us_o    (result),
    .result_valid_o (rv),
    .timeout_o      (to)
  );

  // Event counters sampled before the edge's register updates land.
  always @(posedge clk) begin
    if (rv === 1'b1) n_rv++;
    if (to === 1'b1) n_to++;
    if (rv === 1'b1 && to === 1'b1) n_both++;
    if (trig === 1'b1 && trig_prev_m !== 1'b1) n_rise++;
    trig_prev_m = trig;
  end

  task step();
    @(negedge clk);
    nc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    nrst = 1'b0; start = 1'b0; auto_en = 1'b0; echo = 1'b0;
    repeat (3) step();
    chk("rst_trig", trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", rv, 0);
    chk("rst_timeout", to, 0);
    nrst = 1'b1;
    repeat (2) step();

    // Scenario 1+2: single start, 50-tick echo
    chk("t1_trig_before", trig, 0);
    rv0 = n_rv; to0 = n_to;
    start = 1'b1;
    step();
    start = 1'b0;
    r0 = nc;
    chk("t1_trig_rise", trig, 1);
    chk("t1_busy", busy, 1);
    hi = 0;
    while (trig === 1'b1 && hi < 50) begin hi++; step(); end
    chk("t1_trig_width", hi, 10);
    repeat (80) step();
    echo = 1'b1;
    repeat (200) step();
    echo = 1'b0;
    for (int i = 0; i < 1000 && busy !== 1'b0; i++) step();
    chk("t2_busy_fall", busy, 0);
    chk("t2_busy_fall_at", nc - r0, 800);
    chk("t2_valid_count", n_rv - rv0, 1);
    chk("t2_timeout_count", n_to - to0, 0);
    chk("t2_result_range", (result >= 16'd49 && result <= 16'd51), 1);

    // Scenario 3: no echo
    rv0 = n_rv; to0 = n_to;
    start = 1'b1;
    step();
    start = 1'b0;
    r0 = nc;
    for (int i = 0; i < 600 && to !== 1'b1; i++) step();
    chk("t3_timeout_seen", to, 1);
    t_to = nc - r0;
    chk("t3_timeout_at", (t_to >= 406 && t_to <= 414), 1);
    chk("t3_result_kept", (result >= 16'd49 && result <= 16'd51), 1);
    step();
    chk("t3_timeout_one_cycle", to, 0);
    for (int i = 0; i < 1000 && busy !== 1'b0; i++) step();
    chk("t3_busy_fall_at", nc - r0, 800);
    chk("t3_valid_count", n_rv - rv0, 0);
    chk("t3_timeout_count", n_to - to0, 1);

    // Scenario 4: echo stuck high 150 ticks
    rv0 = n_rv; to0 = n_to;
    start = 1'b1;
    step();
    start = 1'b0;
    r0 = nc;
    repeat (30) step();
    echo = 1'b1;
    e0 = nc;
    for (int i = 0; i < 600 && to !== 1'b1; i++) step();
    chk("t4_timeout_seen", to, 1);
    t_to = nc - e0;
    chk("t4_timeout_at", (t_to >= 399 && t_to <= 407), 1);
    chk("t4_no_valid_with_timeout", rv, 0);
    while (nc - e0 < 600) step();
    echo = 1'b0;
    for (int i = 0; i < 1000 && busy !== 1'b0; i++) step();
    chk("t4_busy_fall_at", nc - r0, 800);
    chk("t4_valid_count", n_rv - rv0, 0);
    chk("t4_timeout_count", n_to - to0, 1);
    chk("t4_result_kept", (result >= 16'd49 && result <= 16'd51), 1);

    // Scenario 5: auto re-trigger, 30-tick echoes, stray start mid-cycle
    rise0 = n_rise; to0 = n_to;
    auto_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000 && trig !== 1'b1; i++) step();
      chk("t5_trig_rise", trig, 1);
      rise_at[k] = nc;
      if (k > 0) chk("t5_trig_period", rise_at[k] - rise_at[k-1], 800);
      for (int i = 0; i < 20 && trig !== 1'b0; i++) step();
      repeat (40) step();
      echo = 1'b1;
      repeat (120) step();
      echo = 1'b0;
      for (int i = 0; i < 20 && rv !== 1'b1; i++) step();
      chk("t5_valid", rv, 1);
      chk("t5_result_range", (result >= 16'd29 && result <= 16'd31), 1);
      if (k == 1) begin
        step();
        start = 1'b1;
        step();
        start = 1'b0;
      end
      if (k == 2) auto_en = 1'b0;
    end
    for (int i = 0; i < 1000 && busy !== 1'b0; i++) step();
    chk("t5_busy_fall", busy, 0);
    chk("t5_trig_count", n_rise - rise0, 3);
    chk("t5_timeout_count", n_to - to0, 0);

    // Scenario 6: async reset mid-MEASURE, then normal measurement
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && trig !== 1'b0; i++) step();
    repeat (20) step();
    echo = 1'b1;
    repeat (40) step();
    chk("t6_busy_before_rst", busy, 1);
    #2 nrst = 1'b0;
    #1;
    chk("t6_rst_trig", trig, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_result", result, 0);
    chk("t6_rst_valid", rv, 0);
    chk("t6_rst_timeout", to, 0);
    echo = 1'b0;
    repeat (3) step();
    nrst = 1'b1;
    repeat (2) step();
    rv0 = n_rv; to0 = n_to;
    start = 1'b1;
    step();
    start = 1'b0;
    r0 = nc;
    chk("t6_trig_rise", trig, 1);
    for (int i = 0; i < 20 && trig !== 1'b0; i++) step();
    chk("t6_trig_width", nc - r0, 10);
    repeat (80) step();
    echo = 1'b1;
    repeat (200) step();
    echo = 1'b0;
    for (int i = 0; i < 1000 && busy !== 1'b0; i++) step();
    chk("t6_busy_fall_at", nc - r0, 800);
    chk("t6_valid_count", n_rv - rv0, 1);
    chk("t6_timeout_count", n_to - to0, 0);
    chk("t6_result_range", (result >= 16'd49 && result <= 16'd51), 1);

    chk("valid_timeout_overlap", n_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ultrasonic_ranger_ctrl.md
Name: ultrasonic_ranger_ctrl

Overview:
Drives the HC-SR04-style ultrasonic sensor. It issues the trigger pulse, waits for the echo, and times the echo high width in microseconds. It reports the width as a 16-bit result with a valid strobe. It sits between the sensor pins (trig out, echo in) and the display/distance-conversion logic, and replaces the free-running 16-bit count with a controlled, gated measurement.

Parameters:
CLK_FREQ_HZ, 27_000_000, system clock frequency; informational, used only to derive defaults.
TICK_DIV, 27, clk cycles per 1 us measurement tick; must be ≥2.
TRIG_CYCLES, 270, trig high width in clk cycles (10 us at 27 MHz).
ECHO_TIMEOUT_US, 38000, max ticks allowed in WAIT_RISE, and separately in MEASURE, before a timeout.
HOLDOFF_US, 60000, ticks from trig rising edge to the earliest next trigger.

Ports:
clk  in  1  system clock, all logic on rising edge
nrst  in  1  asynchronous active-low reset
start  in  1  single-cycle request for one measurement
auto_en  in  1  when 1, re-triggers automatically after holdoff
echo  in  1  raw sensor echo, asynchronous to clk
trig  out  1  sensor trigger pulse, registered
busy  out  1  high in every state except IDLE
result_us  out  16  last valid echo width in us; holds until the next valid result
result_valid  out  1  one-cycle strobe when result_us updates
timeout  out  1  one-cycle strobe on a wait-rise or measure timeout

Behaviour:
- Reset is nrst, asynchronous, active-low; the clock is clk. On reset: state=IDLE, trig=0, busy=0, result_us=0, result_valid=0, timeout=0, prescaler=0, tick counter=0, echo synchroniser=0.
- Echo input: 2-FF synchroniser, then a registered previous value for edge detection. Internal echo_s lags the pin by 2 clk; rise/fall detect lags by 3 clk.
- Tick: prescaler counts 0..TICK_DIV-1 and emits a 1-cycle tick at wrap. The prescaler is cleared on every state entry, so the first tick arrives TICK_DIV cycles after entry.
- Tick counter: 16-bit, cleared on state entry, increments on tick, saturates at 16'hFFFF and never wraps.
- States:
  - IDLE: trig=0. Go to TRIG on start=1, or when auto_en=1 and the previous cycle completed.
  - TRIG: trig=1 for exactly TRIG_CYCLES clk cycles (cycle counter, not ticks), then go to WAIT_RISE with trig=0.
  - WAIT_RISE: on echo rise → MEASURE. If the tick counter reaches ECHO_TIMEOUT_US → timeout strobe, then HOLDOFF.
  - MEASURE: the tick counter counts the echo width. On echo fall → result_us=tick counter value, result_valid strobe, then HOLDOFF. If the counter reaches ECHO_TIMEOUT_US → timeout strobe, result_us unchanged, then HOLDOFF.
  - HOLDOFF: waits until HOLDOFF_US ticks have elapsed since trig rose (a separate 16-bit holdoff tick counter started at TRIG entry), then goes to IDLE. When auto_en=1, go directly to TRIG instead.
- Resolution: result is floor(width/1 us), ±1 tick.
- start while busy=1 is ignored, not queued.
- Simultaneous echo fall and timeout in the same cycle: the fall wins, giving a valid result and no timeout.
- Echo already high at WAIT_RISE entry gives no rise edge; the block waits for a clean rise or times out.
- Echo glitches in HOLDOFF/IDLE are ignored.
- nrst low in any state aborts immediately: trig drops asynchronously to 0 and result_us clears to 0.
- result_valid and timeout are never high in the same cycle.

Decomposition:
- Package ultrasonic_pkg: state enum typedef (IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF), 16-bit tick_t typedef, default timing constants.
- One natural sub-module: us_tick_gen (prescaler producing the 1-cycle tick, with sync clear input).
- Synchroniser and edge detect stay inline.

Test Plan:
Use a sim override: TICK_DIV=4, TRIG_CYCLES=10, ECHO_TIMEOUT_US=100, HOLDOFF_US=200.
1. Reset release, then start pulse → trig high exactly 10 cycles starting 1 cycle after start; busy high from the same cycle.
2. Echo rises 20 ticks after trig falls and is held high 50 ticks (200 clk) → result_valid pulse once, result_us=50 (49..51 accepted), timeout stays 0.
3. No echo → timeout pulse 100 ticks after WAIT_RISE entry, result_us keeps its prior value, busy falls once 200 ticks after trig rise.
4. Echo stuck high for 150 ticks after rising → timeout at 100 ticks in MEASURE, no result_valid.
5. auto_en=1 with echo width 30 ticks → trig rising edges exactly 200 ticks (800 clk) apart over 3 cycles, each giving result_us=30; a start pulse mid-cycle produces no extra trig.
6. nrst asserted mid-MEASURE → trig=0, busy=0, result_us=0 immediately, all strobes 0. After release, a fresh start gives normal operation (scenario 2 values).
